// File: rtl/procom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : procom_pkg
// Description : Shared definitions for the convolution result path: the
//               collect/readout state encoding, a constant-width helper and
//               the output-image size derivation (also used by bram_control).
// Revision    : 1.0 - initial release
// ============================================================================
package procom_pkg;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_READOUT = 1'b1
   } state_t;

   // Number of bits needed to represent 'value'; never less than 1.
   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

   // Valid-convolution output size along one dimension.
   function automatic int out_dim(input int image_dim, input int kernel_dim);
      return image_dim - kernel_dim + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_bram.sv
`default_nettype none
// ============================================================================
// Module      : sdp_bram
// Description : Simple dual-port block RAM, one write port and one read port
//               with a registered output. Contents are never cleared; only
//               the read data register is reset.
// Ports       : clk      - clock, rising edge
//               reset    - asynchronous, active-low (read register only)
//               wr_en    - write strobe
//               wr_addr  - write address
//               wr_data  - write data
//               rd_en    - read strobe, data appears next cycle
//               rd_addr  - read address
//               rd_data  - registered read data, holds when rd_en=0
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_bram
   import procom_pkg::*;
#(
   parameter int RAM_WIDTH = 8,
   parameter int RAM_DEPTH = 64,
   parameter int ADDR_W    = clogb2(RAM_DEPTH - 1)
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [RAM_WIDTH-1:0] wr_data,
   input  logic                 rd_en,
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic [RAM_WIDTH-1:0] rd_data
);

   logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

   // Storage array carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule
`default_nettype wire

// File: rtl/conv_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : conv_result_writer
// Description : Collects convolution result pixels into an internal BRAM in
//               raster order (transposing a column-major input stream when
//               COLUMN_MAJOR=1), then serves the completed frame to the host
//               one word per read strobe.
// Ports       : clk               - clock, rising edge
//               reset             - asynchronous, active-low
//               i_valid_from_conv - result pixel present on i_from_conv
//               i_from_conv       - result pixel
//               i_read_valid      - host read strobe
//               o_data_from_mem   - registered read data
//               o_read_data_valid - o_data_from_mem updated this cycle
//               o_frame_ready     - full frame stored, readout allowed
//               o_read_done       - pulse with the last word of a frame
//               o_overflow        - sticky: pixel arrived during readout
// Revision    : 1.0 - initial release
// ============================================================================
module conv_result_writer
   import procom_pkg::*;
#(
   parameter int RAM_WIDTH    = 8,
   parameter int IMAGE_WIDTH  = 10,
   parameter int IMAGE_HEIGHT = 10,
   parameter int KERNEL_WIDTH = 3,
   parameter int COLUMN_MAJOR = 1
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_valid_from_conv,
   input  logic [RAM_WIDTH-1:0] i_from_conv,
   input  logic                 i_read_valid,
   output logic [RAM_WIDTH-1:0] o_data_from_mem,
   output logic                 o_read_data_valid,
   output logic                 o_frame_ready,
   output logic                 o_read_done,
   output logic                 o_overflow
);

   localparam int OUT_W  = out_dim(IMAGE_WIDTH, KERNEL_WIDTH);
   localparam int OUT_H  = out_dim(IMAGE_HEIGHT, KERNEL_WIDTH);
   localparam int N_PIX  = OUT_W * OUT_H;
   localparam int ADDR_W = clogb2(N_PIX - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

   state_t            state;
   state_t            state_next;
   logic              wr_en;
   logic              rd_en;
   logic              ovf_set;
   logic              wr_last;
   logic              rd_last;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;

   // ------------------------------------------------------------------------
   // Control FSM. Writes happen only in COLLECT and reads only in READOUT,
   // so the BRAM never sees a read and write of the same address together.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_COLLECT;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      ovf_set    = 1'b0;
      case (state)
         ST_COLLECT: begin
            if (i_valid_from_conv) begin
               wr_en = 1'b1;
               if (wr_last) state_next = ST_READOUT;
            end
         end
         ST_READOUT: begin
            ovf_set = i_valid_from_conv;
            if (i_read_valid) begin
               rd_en = 1'b1;
               if (rd_last) state_next = ST_COLLECT;
            end
         end
         default: state_next = ST_COLLECT;
      endcase
   end

   // ------------------------------------------------------------------------
   // Write address generation
   // ------------------------------------------------------------------------
   generate
      if (COLUMN_MAJOR != 0) begin : g_column_major
         localparam int COL_W = clogb2(OUT_W - 1);
         localparam int ROW_W = clogb2(OUT_H - 1);

         logic [COL_W-1:0] col;
         logic [ROW_W-1:0] row;
         logic             row_wrap;

         assign row_wrap = (row == ROW_W'(OUT_H - 1));
         assign wr_last  = row_wrap && (col == COL_W'(OUT_W - 1));
         // Transpose on the fly: constant multiply only.
         assign wr_addr  = ADDR_W'(row) * ADDR_W'(OUT_W) + ADDR_W'(col);

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               col <= '0;
               row <= '0;
            end else if (wr_en) begin
               if (wr_last) begin
                  col <= '0;
                  row <= '0;
               end else if (row_wrap) begin
                  row <= '0;
                  col <= col + 1'b1;
               end else begin
                  row <= row + 1'b1;
               end
            end
         end
      end else begin : g_raster
         logic [ADDR_W-1:0] lin;

         assign wr_addr = lin;
         assign wr_last = (lin == LAST_ADDR);

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)     lin <= '0;
            else if (wr_en) lin <= wr_last ? '0 : lin + 1'b1;
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Read address and output flags
   // ------------------------------------------------------------------------
   assign rd_last = (rd_addr == LAST_ADDR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_addr           <= '0;
         o_read_data_valid <= 1'b0;
         o_read_done       <= 1'b0;
         o_overflow        <= 1'b0;
      end else begin
         if (rd_en) rd_addr <= rd_last ? '0 : rd_addr + 1'b1;
         o_read_data_valid <= rd_en;
         o_read_done       <= rd_en && rd_last;
         o_overflow        <= o_overflow || ovf_set;
      end
   end

   // Registered state already gives the one-cycle delay after the last write.
   assign o_frame_ready = (state == ST_READOUT);

   sdp_bram #(
      .RAM_WIDTH (RAM_WIDTH),
      .RAM_DEPTH (N_PIX),
      .ADDR_W    (ADDR_W)
   ) u_bram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (i_from_conv),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (o_data_from_mem)
   );

endmodule
`default_nettype wire

// File: tb/tb_conv_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_result_writer
// Description : Scoreboard bench for conv_result_writer. Two instances are
//               used: A with column-major input, B with raster input. A
//               reference image is built from the pixel order rules; read
//               strobes push expected words, monitors pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_result_writer;

   localparam int IMAGE_WIDTH  = 10;
   localparam int IMAGE_HEIGHT = 10;
   localparam int KERNEL_WIDTH = 3;
   localparam int OUT_W        = IMAGE_WIDTH - KERNEL_WIDTH + 1;
   localparam int OUT_H        = IMAGE_HEIGHT - KERNEL_WIDTH + 1;
   localparam int N            = OUT_W * OUT_H;

   typedef struct {
      logic [7:0] data;
      bit         done;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       valid_a, rd_a, valid_b, rd_b;
   logic [7:0] pix_a, pix_b;
   logic [7:0] data_a, data_b;
   logic       rdv_a, ready_a, done_a, ovf_a;
   logic       rdv_b, ready_b, done_b, ovf_b;

   exp_t       q_a[$];
   exp_t       q_b[$];
   logic [7:0] ref_a [N];
   logic [7:0] ref_b [N];
   bit         exp_rd_a, exp_rd_b, pend_a, pend_b;
   int         n_checks;
   int         n_fail;

   conv_result_writer #(
      .RAM_WIDTH(8), .IMAGE_WIDTH(IMAGE_WIDTH), .IMAGE_HEIGHT(IMAGE_HEIGHT),
      .KERNEL_WIDTH(KERNEL_WIDTH), .COLUMN_MAJOR(1)
   ) dut_a (
      .clk(clk), .reset(reset),
      .i_valid_from_conv(valid_a), .i_from_conv(pix_a), .i_read_valid(rd_a),
      .o_data_from_mem(data_a), .o_read_data_valid(rdv_a),
      .o_frame_ready(ready_a), .o_read_done(done_a), .o_overflow(ovf_a)
   );

   conv_result_writer #(
      .RAM_WIDTH(8), .IMAGE_WIDTH(IMAGE_WIDTH), .IMAGE_HEIGHT(IMAGE_HEIGHT),
      .KERNEL_WIDTH(KERNEL_WIDTH), .COLUMN_MAJOR(0)
   ) dut_b (
      .clk(clk), .reset(reset),
      .i_valid_from_conv(valid_b), .i_from_conv(pix_b), .i_read_valid(rd_b),
      .o_data_from_mem(data_b), .o_read_data_valid(rdv_b),
      .o_frame_ready(ready_b), .o_read_done(done_b), .o_overflow(ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Strobes accepted in one cycle must produce read data in the next.
   always @(posedge clk) begin
      pend_a <= exp_rd_a;
      pend_b <= exp_rd_b;
   end

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (reset) begin
         check("rd_valid_a", rdv_a, pend_a);
         if (rdv_a) begin
            if (q_a.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_word_a: got %0h, expected no word", data_a);
            end else begin
               e = q_a.pop_front();
               check("rd_data_a", data_a, e.data);
               check("rd_done_a", done_a, e.done);
            end
         end else check("rd_done_idle_a", done_a, 0);
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (reset) begin
         check("rd_valid_b", rdv_b, pend_b);
         if (rdv_b) begin
            if (q_b.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_word_b: got %0h, expected no word", data_b);
            end else begin
               e = q_b.pop_front();
               check("rd_data_b", data_b, e.data);
               check("rd_done_b", done_b, e.done);
            end
         end else check("rd_done_idle_b", done_b, 0);
      end
   end

   task automatic set_in(input int sel, input bit v, input logic [7:0] d,
                         input bit rd, input bit accept);
      if (sel == 0) begin
         valid_a = v; pix_a = d; rd_a = rd; exp_rd_a = accept;
      end else begin
         valid_b = v; pix_b = d; rd_b = rd; exp_rd_b = accept;
      end
   endtask

   function automatic logic ready_of(input int sel);
      return (sel == 0) ? ready_a : ready_b;
   endfunction

   // Feed 'count' pixels. mode 0: base+p, mode 1: random values.
   // Instance A is column-major: pixel p lands at col=p/OUT_H, row=p%OUT_H.
   task automatic feed(input int sel, input int count, input int mode, input int base,
                       input int gap_lo, input int gap_hi, input bit strobe);
      int         gap;
      int         idx;
      logic [7:0] v;
      for (int p = 0; p < count; p++) begin
         v = (mode != 0) ? 8'($urandom_range(0, 255)) : 8'(base + p);
         @(negedge clk);
         check("ready_before_full", ready_of(sel), 0);
         set_in(sel, 1'b1, v, strobe, 1'b0);
         if (sel == 0) begin
            idx = (p % OUT_H) * OUT_W + (p / OUT_H);
            ref_a[idx] = v;
         end else begin
            idx = p;
            ref_b[idx] = v;
         end
         if (p != count - 1) begin
            gap = $urandom_range(gap_lo, gap_hi);
            for (int g = 0; g < gap; g++) begin
               @(negedge clk);
               set_in(sel, 1'b0, 8'h00, 1'b0, 1'b0);
            end
         end
      end
      @(negedge clk);
      set_in(sel, 1'b0, 8'h00, 1'b0, 1'b0);
      if (count == N) check("ready_rise", ready_of(sel), 1);
   endtask

   task automatic read_frame(input int sel, input int gap_lo, input int gap_hi);
      exp_t e;
      int   gap;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         check("ready_hold", ready_of(sel), 1);
         set_in(sel, 1'b0, 8'h00, 1'b1, 1'b1);
         e.data = (sel == 0) ? ref_a[k] : ref_b[k];
         e.done = (k == N - 1);
         if (sel == 0) q_a.push_back(e);
         else          q_b.push_back(e);
         if (k != N - 1) begin
            gap = $urandom_range(gap_lo, gap_hi);
            for (int g = 0; g < gap; g++) begin
               @(negedge clk);
               set_in(sel, 1'b0, 8'h00, 1'b0, 1'b0);
            end
         end
      end
      @(negedge clk);
      set_in(sel, 1'b0, 8'h00, 1'b0, 1'b0);
      check("ready_fall", ready_of(sel), 0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      set_in(0, 1'b0, 8'h00, 1'b0, 1'b0);
      set_in(1, 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      check("rst_data_a", data_a, 0);
      check("rst_rdv_a", rdv_a, 0);
      check("rst_ready_a", ready_a, 0);
      check("rst_done_a", done_a, 0);
      check("rst_ovf_a", ovf_a, 0);
      check("rst_ready_b", ready_b, 0);
      check("rst_ovf_b", ovf_b, 0);
      reset = 1'b1;

      // Column-major fill 0..63, back-to-back readout (transposed).
      feed(0, N, 0, 0, 0, 0, 1'b0);
      read_frame(0, 0, 0);

      // Gapped input (1 in 3) then gapped reads (every other cycle).
      feed(0, N, 0, 0, 2, 2, 1'b0);
      read_frame(0, 1, 1);

      // Random data with random gaps, plus an overflow pulse.
      feed(0, N, 1, 0, 0, 3, 1'b0);
      check("ovf_before", ovf_a, 0);
      @(negedge clk);
      set_in(0, 1'b1, 8'hAA, 1'b0, 1'b0);
      @(negedge clk);
      set_in(0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("ovf_set", ovf_a, 1);
      read_frame(0, 0, 2);
      check("ovf_sticky", ovf_a, 1);

      // Reset in the middle of a frame.
      feed(0, 20, 0, 200, 0, 0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_ready", ready_a, 0);
      check("midrst_ovf", ovf_a, 0);
      check("midrst_data", data_a, 0);
      @(negedge clk);
      check("midrst_ready2", ready_a, 0);
      reset = 1'b1;
      feed(0, N, 0, 100, 0, 0, 1'b0);
      read_frame(0, 0, 0);

      // Raster instance, with ignored read strobes during collection.
      feed(1, N, 0, 0, 0, 1, 1'b1);
      read_frame(1, 0, 0);
      feed(1, N, 1, 0, 0, 2, 1'b1);
      read_frame(1, 0, 1);
      check("ovf_b_clear", ovf_b, 0);

      repeat (3) @(negedge clk);
      check("queue_a_empty", q_a.size(), 0);
      check("queue_b_empty", q_b.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
